// File: rtl/backbone_initial_feeder_pkg.sv
// Shared definitions for the backbone-initial interface: default sizes, width
// derivation and the state encoding common to producer and consumer.
package backbone_initial_feeder_pkg;

  localparam int J_DEFAULT = 14;
  localparam int I_DEFAULT = 7;
  localparam int A_DEFAULT = 2;

  // Width of a counter/index that must also represent the value n itself.
  function automatic int idx_width(input int n);
    return $clog2(n) + 1;
  endfunction

  typedef enum logic [1:0] {
    FILL      = 2'b00,
    ISSUE     = 2'b01,
    WAIT_DONE = 2'b10
  } feeder_state_e;

endpackage

// File: rtl/backbone_initial_feeder_stream_slot_loader.sv
// Generic ready/valid collector: writes each accepted beat into the next slot
// of a packed register bank and drops ready once every slot is filled.
module stream_slot_loader #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 28,
  parameter int CNT_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [DATA_W-1:0]       s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [CNT_W-1:0]        cnt,
  output logic [DEPTH*DATA_W-1:0] bank
);

  logic accept;

  assign s_tready = (cnt < CNT_W'(DEPTH));
  assign accept   = s_tvalid & s_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The bank is not wiped on clear; every slot is overwritten by the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank <= '0;
    end else if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt == CNT_W'(i)) begin
          bank[i*DATA_W +: DATA_W] <= s_tdata;
        end
      end
    end
  end

endmodule

// File: rtl/backbone_initial_feeder.sv
// Producer side of the backbone-initial interface: packs alpha_u and x_initial
// streams, pulses the three tvalids, and holds until the consumer is done.
// Optional protocol checking (tlast placement, stray done) with BACKBONE_FEEDER_CHECK_EN.
module backbone_initial_feeder
  import backbone_initial_feeder_pkg::*;
#(
  parameter  int J       = J_DEFAULT,
  parameter  int I       = I_DEFAULT,
  parameter  int A       = A_DEFAULT,
  localparam int J_WIDTH = idx_width(J),
  localparam int A_WIDTH = idx_width(A),
  localparam int K_WIDTH = idx_width(J*A)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [63:0]            s_alpha_tdata,
  input  logic                   s_alpha_tvalid,
  output logic                   s_alpha_tready,
  input  logic                   s_alpha_tlast,
  input  logic [A_WIDTH-1:0]     s_x_tdata,
  input  logic                   s_x_tvalid,
  output logic                   s_x_tready,
  input  logic [J_WIDTH-1:0]     cfg_ind_j,
  input  logic                   backbone_initial_tvalid,
  output logic [J*A*64-1:0]      alpha_u,
  output logic                   alpha_u_tvalid,
  output logic [J*A_WIDTH-1:0]   x_initial,
  output logic                   x_initial_tvalid,
  output logic [J_WIDTH-1:0]     ind_j,
  output logic                   ind_j_tvalid,
  output logic [15:0]            frame_cnt,
  output logic                   err_flag
);

  feeder_state_e        state_q, state_d;
  logic [K_WIDTH-1:0]   alpha_cnt;
  logic [J_WIDTH-1:0]   x_cnt;
  logic [J_WIDTH-1:0]   ind_j_q;
  logic [15:0]          frame_cnt_q;
  logic                 frame_full;
  logic                 done_accept;
  logic [31:0]          unused_i;

  assign unused_i = I;

  assign frame_full  = (alpha_cnt == K_WIDTH'(J*A)) && (x_cnt == J_WIDTH'(J));
  assign done_accept = (state_q == WAIT_DONE) && backbone_initial_tvalid;

  stream_slot_loader #(
    .DATA_W (64),
    .DEPTH  (J*A),
    .CNT_W  (K_WIDTH)
  ) u_alpha_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (done_accept),
    .s_tdata  (s_alpha_tdata),
    .s_tvalid (s_alpha_tvalid),
    .s_tready (s_alpha_tready),
    .cnt      (alpha_cnt),
    .bank     (alpha_u)
  );

  stream_slot_loader #(
    .DATA_W (A_WIDTH),
    .DEPTH  (J),
    .CNT_W  (J_WIDTH)
  ) u_x_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (done_accept),
    .s_tdata  (s_x_tdata),
    .s_tvalid (s_x_tvalid),
    .s_tready (s_x_tready),
    .cnt      (x_cnt),
    .bank     (x_initial)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:      if (frame_full) state_d = ISSUE;
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: if (backbone_initial_tvalid) state_d = FILL;
      default:   state_d = FILL;
    endcase
  end

  always_comb begin
    alpha_u_tvalid   = 1'b0;
    x_initial_tvalid = 1'b0;
    ind_j_tvalid     = 1'b0;
    if (state_q == ISSUE) begin
      alpha_u_tvalid   = 1'b1;
      x_initial_tvalid = 1'b1;
      ind_j_tvalid     = 1'b1;
    end
  end

  // ind_j is captured on the FILL->ISSUE edge so it is valid alongside the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ind_j_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      if ((state_q == FILL) && frame_full) ind_j_q <= cfg_ind_j;
      if (done_accept) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign ind_j     = ind_j_q;
  assign frame_cnt = frame_cnt_q;

`ifdef BACKBONE_FEEDER_CHECK_EN
  logic err_q;
  logic alpha_accept;
  logic alpha_last_beat;

  assign alpha_accept    = s_alpha_tvalid & s_alpha_tready;
  assign alpha_last_beat = (alpha_cnt == K_WIDTH'(J*A - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((alpha_accept && (s_alpha_tlast != alpha_last_beat)) ||
                 (backbone_initial_tvalid && (state_q != WAIT_DONE))) begin
      err_q <= 1'b1;
    end
  end

  assign err_flag = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_alpha_tlast;
  assign err_flag     = 1'b0;
`endif

endmodule

// File: tb/tb_backbone_initial_feeder.sv
// Directed scoreboard bench for backbone_initial_feeder (J=14, A=2); expected
// frames are queued as they are driven and popped when the tvalid pulse appears.
module tb_backbone_initial_feeder;
  import backbone_initial_feeder_pkg::*;

  localparam int J  = 14;
  localparam int A  = 2;
  localparam int AW = 2;
  localparam int JW = 5;
  localparam int NK = J*A;

`ifdef BACKBONE_FEEDER_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [63:0]       s_alpha_tdata;
  logic              s_alpha_tvalid;
  logic              s_alpha_tready;
  logic              s_alpha_tlast;
  logic [AW-1:0]     s_x_tdata;
  logic              s_x_tvalid;
  logic              s_x_tready;
  logic [JW-1:0]     cfg_ind_j;
  logic              backbone_initial_tvalid;
  logic [NK*64-1:0]  alpha_u;
  logic              alpha_u_tvalid;
  logic [J*AW-1:0]   x_initial;
  logic              x_initial_tvalid;
  logic [JW-1:0]     ind_j;
  logic              ind_j_tvalid;
  logic [15:0]       frame_cnt;
  logic              err_flag;

  typedef struct {
    logic [NK*64-1:0] alpha;
    logic [J*AW-1:0]  x;
    logic [JW-1:0]    ind;
  } sb_item_t;

  sb_item_t    sb_q[$];
  sb_item_t    last_item;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  logic [15:0] exp_frames;

  backbone_initial_feeder #(.J(J), .I(7), .A(A)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .s_alpha_tdata           (s_alpha_tdata),
    .s_alpha_tvalid          (s_alpha_tvalid),
    .s_alpha_tready          (s_alpha_tready),
    .s_alpha_tlast           (s_alpha_tlast),
    .s_x_tdata               (s_x_tdata),
    .s_x_tvalid              (s_x_tvalid),
    .s_x_tready              (s_x_tready),
    .cfg_ind_j               (cfg_ind_j),
    .backbone_initial_tvalid (backbone_initial_tvalid),
    .alpha_u                 (alpha_u),
    .alpha_u_tvalid          (alpha_u_tvalid),
    .x_initial               (x_initial),
    .x_initial_tvalid        (x_initial_tvalid),
    .ind_j                   (ind_j),
    .ind_j_tvalid            (ind_j_tvalid),
    .frame_cnt               (frame_cnt),
    .err_flag                (err_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] alpha_val(input int base, input int k);
    return $realtobits(real'(base + k + 1));
  endfunction

  // x values 2 and 3 exceed A-1 and must pass through unchanged.
  function automatic logic [AW-1:0] x_val(input int base, input int j);
    if (base == 0) return AW'(j % 2);
    return AW'((j + base) % 4);
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one full frame on both streams, pushing its expected image first.
  task automatic apply_stimulus(input int base, input int x_delay, input bit gaps,
                                input int extra_last, input logic [JW-1:0] ind,
                                output int last_cyc);
    sb_item_t item;
    int ai, xi, steps;
    bit av, xv, aacc, xacc;
    for (int k = 0; k < NK; k++) item.alpha[k*64 +: 64] = alpha_val(base, k);
    for (int j = 0; j < J; j++) item.x[j*AW +: AW] = x_val(base, j);
    item.ind = ind;
    sb_q.push_back(item);
    cfg_ind_j = ind;
    ai = 0; xi = 0; steps = 0; last_cyc = 0;
    while ((ai < NK || xi < J) && steps < 2000) begin
      av = (ai < NK) && (!gaps || $urandom_range(0, 3) != 0);
      xv = (xi < J) && (steps >= x_delay) && (!gaps || $urandom_range(0, 2) != 0);
      s_alpha_tvalid = av;
      s_alpha_tdata  = alpha_val(base, ai);
      s_alpha_tlast  = (ai == NK - 1) || (ai == extra_last);
      s_x_tvalid     = xv;
      s_x_tdata      = x_val(base, xi);
      @(negedge clk);
      aacc = av && s_alpha_tready;
      xacc = xv && s_x_tready;
      @(posedge clk); #1;
      if (aacc) ai++;
      if (xacc) xi++;
      if (aacc || xacc) last_cyc = cyc - 1;
      steps++;
    end
    s_alpha_tvalid = 1'b0;
    s_alpha_tlast  = 1'b0;
    s_x_tvalid     = 1'b0;
    check_output("beats_accepted", 64'(ai + xi), 64'(NK + J));
  endtask

  task automatic wait_pulse(input int exp_cyc);
    sb_item_t item;
    int n;
    n = 0;
    while (alpha_u_tvalid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("pulse_seen", 64'(alpha_u_tvalid), 64'd1);
    check_output("pulse_cycle", 64'(cyc), 64'(exp_cyc));
    check_output("x_tvalid_pulse", 64'(x_initial_tvalid), 64'd1);
    check_output("ind_tvalid_pulse", 64'(ind_j_tvalid), 64'd1);
    check_output("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      item = sb_q.pop_front();
      for (int k = 0; k < NK; k++)
        check_output($sformatf("alpha_u[%0d]", k), alpha_u[k*64 +: 64], item.alpha[k*64 +: 64]);
      for (int j = 0; j < J; j++)
        check_output($sformatf("x_initial[%0d]", j), 64'(x_initial[j*AW +: AW]), 64'(item.x[j*AW +: AW]));
      check_output("ind_j", 64'(ind_j), 64'(item.ind));
      last_item = item;
    end
    @(posedge clk); #1;
    check_output("pulse_width", 64'({alpha_u_tvalid, x_initial_tvalid, ind_j_tvalid}), 64'd0);
  endtask

  task automatic finish_frame();
    @(posedge clk); #1;
    backbone_initial_tvalid = 1'b1;
    @(posedge clk); #1;
    backbone_initial_tvalid = 1'b0;
    exp_frames = exp_frames + 16'd1;
    check_output("frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    check_output("readies_after_done", 64'({s_alpha_tready, s_x_tready}), 64'd3);
  endtask

  initial begin
    int lc, bp_ready_bad, bp_pulse;

    rst_n = 1'b0;
    s_alpha_tdata = '0; s_alpha_tvalid = 1'b0; s_alpha_tlast = 1'b0;
    s_x_tdata = '0; s_x_tvalid = 1'b0; cfg_ind_j = '0;
    backbone_initial_tvalid = 1'b0;
    exp_frames = 16'd0;
    #1;
    check_output("rst_alpha_u0", alpha_u[63:0], 64'd0);
    check_output("rst_tvalids", 64'({alpha_u_tvalid, x_initial_tvalid, ind_j_tvalid}), 64'd0);
    check_output("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check_output("rst_err", 64'(err_flag), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("idle_readies", 64'({s_alpha_tready, s_x_tready}), 64'd3);

    // Nominal frame: alpha 1.0..28.0, x = j%2, ind 5.
    $display("[TB] nominal frame");
    apply_stimulus(0, 0, 1'b0, -1, 5'd5, lc);
    wait_pulse(lc + 2);
    check_output("alpha27_is_28.0", alpha_u[27*64 +: 64], 64'h403C000000000000);
    check_output("alpha0_is_1.0", alpha_u[63:0], 64'h3FF0000000000000);
    check_output("x13", 64'(x_initial[13*AW +: AW]), 64'd1);
    check_output("ind_j_5", 64'(ind_j), 64'd5);

    // Backpressure: consumer silent for 50 cycles while a new frame is offered.
    $display("[TB] backpressure");
    bp_ready_bad = 0; bp_pulse = 0;
    s_alpha_tvalid = 1'b1; s_alpha_tdata = alpha_val(900, 0);
    s_x_tvalid = 1'b1; s_x_tdata = 2'd3; cfg_ind_j = 5'd9;
    repeat (50) begin
      @(negedge clk);
      if (s_alpha_tready !== 1'b0 || s_x_tready !== 1'b0) bp_ready_bad++;
      if (alpha_u_tvalid !== 1'b0 || x_initial_tvalid !== 1'b0 || ind_j_tvalid !== 1'b0) bp_pulse++;
    end
    check_output("bp_ready_low", 64'(bp_ready_bad), 64'd0);
    check_output("bp_no_pulse", 64'(bp_pulse), 64'd0);
    check_output("bp_alpha_hold", alpha_u[27*64 +: 64], last_item.alpha[27*64 +: 64]);
    check_output("bp_alpha0_hold", alpha_u[63:0], last_item.alpha[63:0]);
    check_output("bp_x_hold", 64'(x_initial), 64'(last_item.x));
    check_output("bp_ind_hold", 64'(ind_j), 64'd5);
    s_alpha_tvalid = 1'b0; s_x_tvalid = 1'b0;
    finish_frame();

    // Bursty inputs with x finishing well after alpha.
    $display("[TB] bursty interleaved");
    apply_stimulus(100, 24, 1'b1, -1, 5'd12, lc);
    wait_pulse(lc + 2);
    finish_frame();

    // Spurious done in FILL, then an early tlast on beat 20.
    $display("[TB] spurious done and tlast");
    backbone_initial_tvalid = 1'b1;
    @(posedge clk); #1;
    backbone_initial_tvalid = 1'b0;
    check_output("spur_readies", 64'({s_alpha_tready, s_x_tready}), 64'd3);
    check_output("spur_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    check_output("spur_no_pulse", 64'(alpha_u_tvalid), 64'd0);
    check_output("spur_err", 64'(err_flag), 64'(CHECK_EN));
    apply_stimulus(200, 0, 1'b0, 20, 5'd3, lc);
    wait_pulse(lc + 2);
    check_output("tlast_err", 64'(err_flag), 64'(CHECK_EN));
    finish_frame();
    check_output("err_sticky", 64'(err_flag), 64'(CHECK_EN));

    // Frame counter wrap from a forced 65535.
    $display("[TB] frame counter wrap");
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt_q;
    exp_frames = 16'hFFFF;
    check_output("wrap_preload", 64'(frame_cnt), 64'hFFFF);
    apply_stimulus(300, 3, 1'b0, -1, 5'd13, lc);
    wait_pulse(lc + 2);
    finish_frame();
    check_output("wrap_zero", 64'(frame_cnt), 64'd0);

    // Mid-frame asynchronous reset after 13 alpha beats.
    $display("[TB] mid-frame reset");
    for (int i = 0; i < 13; i++) begin
      s_alpha_tvalid = 1'b1; s_alpha_tdata = alpha_val(400, i);
      s_x_tvalid = 1'b1; s_x_tdata = x_val(400, i);
      @(posedge clk); #1;
    end
    s_alpha_tvalid = 1'b0; s_x_tvalid = 1'b0;
    check_output("pre_rst_alpha0", alpha_u[63:0], alpha_val(400, 0));
    #3 rst_n = 1'b0;
    #1;
    check_output("mid_rst_alpha0", alpha_u[63:0], 64'd0);
    check_output("mid_rst_alpha12", alpha_u[12*64 +: 64], 64'd0);
    check_output("mid_rst_x", 64'(x_initial), 64'd0);
    check_output("mid_rst_ind", 64'(ind_j), 64'd0);
    check_output("mid_rst_err", 64'(err_flag), 64'd0);
    check_output("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_frames = 16'd0;
    apply_stimulus(500, 0, 1'b0, -1, 5'd7, lc);
    wait_pulse(lc + 2);
    finish_frame();
    check_output("post_rst_err", 64'(err_flag), 64'd0);
    check_output("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
